// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: 16-deep byte FIFO drained back-to-back; first start bit 2 clocks after a write, no backpressure (writes when full are dropped and flagged).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_buffered #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int UART_BPS = 9600,
   parameter int FIFO_AW  = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               wr_en,
   input  logic [7:0]         wr_data,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               overflow,
   output logic               tx_busy,
   output logic               tx_done,
   output logic               uart_txd
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam int DEPTH   = 1 << FIFO_AW;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0]   CNT_PRE  = CNT_W'((BPS_CNT > 1) ? BPS_CNT - 2 : 0);
   localparam logic               HAS_PRE  = (BPS_CNT > 1);
   localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               full_q, empty_q, overflow_q;

   state_t             state_q;
   logic [CNT_W-1:0]   baud_q;
   logic [2:0]         bit_q;
   logic [7:0]         shift_q;
   logic               txd_q, done_q;
`ifdef UART_TX_PARITY_EN
   logic               par_q;
`endif

   logic               wr_acc, pop, cnt_last;
   logic [7:0]         head;

   assign head     = mem_q[rd_ptr_q];
   assign cnt_last = (baud_q == CNT_LAST);
   assign wr_acc   = wr_en && !full_q;
   // Pops happen only at frame boundaries, so flags are always valid one cycle later.
   assign pop      = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && cnt_last));

   always_comb begin
      count_d = count_q;
      if (wr_acc && !pop) begin
         count_d = count_q + (FIFO_AW + 1)'(1);
      end else if (!wr_acc && pop) begin
         count_d = count_q - (FIFO_AW + 1)'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (wr_en && full_q) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         empty_q <= (count_d == '0);
      end
   end

   // txd_q always carries the level of the state being entered, so the pin is glitch-free.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               baud_q <= '0;
               txd_q  <= 1'b1;
               if (pop) begin
                  shift_q <= head;
`ifdef UART_TX_PARITY_EN
                  par_q   <= ^head;
`endif
                  state_q <= START;
                  txd_q   <= 1'b0;
               end
            end
            START: begin
               if (cnt_last) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  state_q <= DATA;
                  txd_q   <= shift_q[0];
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state_q <= PARITY;
                     txd_q   <= par_q;
`else
                     state_q <= STOP;
                     txd_q   <= 1'b1;
                     done_q  <= !HAS_PRE;
`endif
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     shift_q <= {1'b0, shift_q[7:1]};
                     txd_q   <= shift_q[1];
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (cnt_last) begin
                  baud_q  <= '0;
                  state_q <= STOP;
                  txd_q   <= 1'b1;
                  done_q  <= !HAS_PRE;
               end else begin
                  baud_q <= baud_q + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt_last) begin
                  baud_q <= '0;
                  if (pop) begin
                     shift_q <= head;
`ifdef UART_TX_PARITY_EN
                     par_q   <= ^head;
`endif
                     state_q <= START;
                     txd_q   <= 1'b0;
                  end else begin
                     state_q <= IDLE;
                     txd_q   <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + 1'b1;
                  done_q <= HAS_PRE && (baud_q == CNT_PRE);
               end
            end
            default: begin
               state_q <= IDLE;
               baud_q  <= '0;
               txd_q   <= 1'b1;
            end
         endcase
      end
   end

   assign fifo_full  = full_q;
   assign fifo_empty = empty_q;
   assign fifo_count = count_q;
   assign overflow   = overflow_q;
   assign tx_busy    = (state_q != IDLE);
   assign tx_done    = done_q;
   assign uart_txd   = txd_q;

endmodule
